// File: rtl/uart_mmio_ctrl.sv
// Purpose: MMIO bridge between the core load/store port and the UART rx/tx cores (baud tick, 4-deep RX FIFO, TX sequencer).
// Latency: register reads return on the cycle after rd_en; an accepted DATA write raises tx_start on the next cycle.
// Backpressure: none on the bus; RX bytes arriving while the FIFO is full are dropped (overrun), and DATA writes while busy are dropped (tx_err).
module uart_mmio_ctrl #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DVSR_RST   = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    addr,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          s_tick,
  input  logic          rx_done_tick,
  input  logic [7:0]    rx_dout,
  output logic          tx_start,
  output logic [7:0]    tx_din,
  input  logic          tx_done_tick,
  output logic          irq_rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_DIVISOR = 2'd2;
  localparam logic [1:0] A_CONTROL = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  // Baud generator state
  logic [15:0] divisor;
  logic [15:0] baud_cnt;
  logic [15:0] eff_dvsr;

  // RX FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  // Status flags and TX sequencer
  logic      overrun;
  logic      tx_err;
  tx_state_t tx_state;

  // Bus decode
  logic wr_data;
  logic wr_div;
  logic wr_ctrl;
  logic rx_valid;
  logic rx_full;
  logic tx_busy;
  logic pop;
  logic push;
  logic flush;
  logic ovr_set;
  logic [4:0] status;

  // Only the low half of the store data is meaningful to any register.
  logic unused_wdata;
  assign unused_wdata = ^wdata[DW-1:16];

  assign wr_data  = wr_en && (addr == A_DATA);
  assign wr_div   = wr_en && (addr == A_DIVISOR);
  assign wr_ctrl  = wr_en && (addr == A_CONTROL);

  assign rx_valid = (count != '0);
  assign rx_full  = (count == CW'(FIFO_DEPTH));
  assign tx_busy  = (tx_state != TX_IDLE);

  // A pop on the same cycle as a full-FIFO arrival frees the slot for it.
  assign flush    = wr_ctrl && wdata[2];
  assign pop      = rd_en && (addr == A_DATA) && rx_valid;
  assign push     = rx_done_tick && (!rx_full || pop) && !flush;
  assign ovr_set  = rx_done_tick && rx_full && !pop && !flush;

  assign status   = {tx_err, tx_busy, overrun, rx_full, rx_valid};

  // A zero divisor would never match a count of -1, so treat it as 1.
  assign eff_dvsr = (divisor == 16'd0) ? 16'd1 : divisor;

  // Next FIFO occupancy; a flush overrides any push or pop in the same cycle.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // Baud tick: one-cycle pulse every eff_dvsr clocks; a divisor write restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= 16'(DVSR_RST);
      baud_cnt <= '0;
      s_tick   <= 1'b0;
    end else if (wr_div) begin
      divisor  <= wdata[15:0];
      baud_cnt <= '0;
      s_tick   <= 1'b0;
    end else if (baud_cnt >= eff_dvsr - 16'd1) begin
      baud_cnt <= '0;
      s_tick   <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
      s_tick   <= 1'b0;
    end
  end

  // RX FIFO storage and pointers; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'd0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      irq_rx <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) begin
          fifo_mem[wptr] <= rx_dout;
          wptr           <= wptr + 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
      end
      count  <= count_nxt;
      irq_rx <= (count_nxt != '0);
    end
  end

  // Sticky overrun: a new loss in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (wr_ctrl && wdata[0]) begin
      overrun <= 1'b0;
    end
  end

  // TX sequencer: latch byte, pulse tx_start once, wait for the core to finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_start <= 1'b0;
      tx_din   <= 8'd0;
      tx_err   <= 1'b0;
    end else begin
      if (wr_ctrl && wdata[1]) tx_err <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_start <= 1'b0;
          if (wr_data) begin
            tx_din   <= wdata[7:0];
            tx_start <= 1'b1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx_start <= 1'b0;
          tx_state <= TX_WAIT;
          if (wr_data) tx_err <= 1'b1;
        end
        TX_WAIT: begin
          tx_start <= 1'b0;
          // A write colliding with tx_done_tick is still treated as busy.
          if (wr_data) tx_err <= 1'b1;
          if (tx_done_tick) tx_state <= TX_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Registered read port; returns pre-write state when a write lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      case (addr)
        A_DATA:    rdata <= rx_valid ? DW'(fifo_mem[rptr]) : '0;
        A_STATUS:  rdata <= DW'(status);
        A_DIVISOR: rdata <= DW'(divisor);
        A_CONTROL: rdata <= '0;
        default:   rdata <= '0;
      endcase
    end else begin
      rdata <= '0;
    end
  end

endmodule
